// File: rtl/tick_generator_param.sv
// Prescaled tick generator driving a wrap-around up/down counter with run,
// clear and clamped preload; everything on one clock, no derived clocks.
module tick_generator_param #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 1_000,
  parameter int CNT_WIDTH = 14,
  parameter int CNT_MAX   = 9999
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_value,
  input  logic                 i_down,
  output logic [CNT_WIDTH-1:0] o_counter,
  output logic                 o_tick,
  output logic                 o_wrap
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_V    = CNT_WIDTH'(CNT_MAX);

  if (DIV < 1) begin : g_bad_div
    $error("tick_generator_param: CLK_HZ/TICK_HZ must be at least 1");
  end
  if (longint'(CNT_MAX) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_max
    $error("tick_generator_param: CNT_MAX does not fit in CNT_WIDTH bits");
  end

  logic [PRE_W-1:0] pre;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pre       <= '0;
      o_counter <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
    end else if (i_clear) begin
      pre       <= '0;
      o_counter <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
    end else if (i_load) begin
      // A tick landing on the same edge is dropped; the prescaler restarts.
      pre       <= '0;
      o_counter <= (i_load_value > MAX_V) ? MAX_V : i_load_value;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
    end else if (i_run) begin
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
      if (pre == PRE_LAST) begin
        pre    <= '0;
        o_tick <= 1'b1;
        if (i_down) begin
          if (o_counter == '0) begin
            o_counter <= MAX_V;
            o_wrap    <= 1'b1;
          end else begin
            o_counter <= o_counter - CNT_WIDTH'(1);
          end
        end else begin
          // ">=" also recovers an out-of-range count on the next up step.
          if (o_counter >= MAX_V) begin
            o_counter <= '0;
            o_wrap    <= 1'b1;
          end else begin
            o_counter <= o_counter + CNT_WIDTH'(1);
          end
        end
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end else begin
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_generator_param.sv
// Directed bench: DIV=10 instance checked every cycle against a cycle-count
// model plus literal expectations; a DIV=1 instance checked by hand values.
module tb_tick_generator_param;

  localparam int DIV  = 10;
  localparam int MAXC = 5;

  logic       clk = 1'b0;
  logic       reset, run, clear, load, down;
  logic [3:0] load_value;
  logic [3:0] counter;
  logic       tick, wrap;
  logic       run1;
  logic [3:0] counter1;
  logic       tick1, wrap1;

  int  pass_cnt  = 0;
  int  total_cnt = 0;
  bit  chk_en    = 1'b0;

  // Model: elapsed run cycles since the last restart, plus the count value.
  int   m_elapsed = 0;
  int   m_cnt     = 0;
  logic m_tick    = 1'b0;
  logic m_wrap    = 1'b0;

  always #5 clk = ~clk;

  tick_generator_param #(
    .CLK_HZ(10), .TICK_HZ(1), .CNT_WIDTH(4), .CNT_MAX(5)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_clear(clear),
    .i_load(load), .i_load_value(load_value), .i_down(down),
    .o_counter(counter), .o_tick(tick), .o_wrap(wrap)
  );

  tick_generator_param #(
    .CLK_HZ(10), .TICK_HZ(10), .CNT_WIDTH(4), .CNT_MAX(5)
  ) dut1 (
    .i_clk(clk), .i_reset(reset), .i_run(run1), .i_clear(1'b0),
    .i_load(1'b0), .i_load_value(4'd0), .i_down(1'b0),
    .o_counter(counter1), .o_tick(tick1), .o_wrap(wrap1)
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_out(input string name, input int c, input int t, input int w);
    check({name, ".counter"}, int'(counter), c);
    check({name, ".tick"}, int'(tick), t);
    check({name, ".wrap"}, int'(wrap), w);
    check({name, ".model"}, m_cnt, c);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (!reset || clear) begin
      m_elapsed <= 0; m_cnt <= 0; m_tick <= 1'b0; m_wrap <= 1'b0;
    end else if (load) begin
      m_elapsed <= 0;
      m_cnt     <= (int'(load_value) > MAXC) ? MAXC : int'(load_value);
      m_tick    <= 1'b0; m_wrap <= 1'b0;
    end else if (run && (m_elapsed + 1 == DIV)) begin
      m_elapsed <= 0;
      m_tick    <= 1'b1;
      if (down) begin
        m_cnt  <= (m_cnt + MAXC) % (MAXC + 1);
        m_wrap <= (m_cnt == 0);
      end else begin
        m_cnt  <= (m_cnt + 1) % (MAXC + 1);
        m_wrap <= (m_cnt == MAXC);
      end
    end else begin
      if (run) m_elapsed <= m_elapsed + 1;
      m_tick <= 1'b0; m_wrap <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc.counter", int'(counter), m_cnt);
      check("cyc.tick", int'(tick), int'(m_tick));
      check("cyc.wrap", int'(wrap), int'(m_wrap));
    end
  end

  initial begin
    int up_seq[5]   = '{2, 3, 4, 5, 0};
    int down_seq[4] = '{1, 0, 5, 4};
    reset = 1'b0; run = 1'b0; clear = 1'b0; load = 1'b0; down = 1'b0;
    load_value = 4'd0; run1 = 1'b0;

    cyc(1);
    chk_en = 1'b1;
    expect_out("reset", 0, 0, 0);
    cyc(2);
    reset = 1'b1; run = 1'b1;

    // Reset then run: first tick a full DIV after release.
    cyc(9);
    expect_out("first_wait", 0, 0, 0);
    cyc(1);
    expect_out("first_tick", 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(10);
      expect_out($sformatf("up_step%0d", i), up_seq[i], 1, (up_seq[i] == 0) ? 1 : 0);
    end

    // Down mode from a load of 2.
    load = 1'b1; load_value = 4'd2; down = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_out("load2", 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(10);
      expect_out($sformatf("dn_step%0d", i), down_seq[i], 1, (down_seq[i] == MAXC) ? 1 : 0);
    end

    // Pause at prescaler=4 for 7 cycles; resumes with 6 cycles to go.
    cyc(4);
    run = 1'b0;
    cyc(7);
    expect_out("paused", 4, 0, 0);
    run = 1'b1;
    cyc(5);
    expect_out("resume_wait", 4, 0, 0);
    cyc(1);
    expect_out("resume_tick", 3, 1, 0);

    // Clamp, clear-over-load, load on a terminal edge.
    load = 1'b1; load_value = 4'd12;
    cyc(1);
    load = 1'b0;
    expect_out("clamp", 5, 0, 0);
    clear = 1'b1; load = 1'b1; load_value = 4'd3;
    cyc(1);
    clear = 1'b0; load = 1'b0;
    expect_out("clear_wins", 0, 0, 0);
    cyc(9);
    load = 1'b1; load_value = 4'd3;
    cyc(1);
    load = 1'b0;
    expect_out("load_on_term", 3, 0, 0);

    // Reset at counter=3, prescaler=7; then a full DIV to the first tick.
    cyc(7);
    reset = 1'b0; down = 1'b0;
    cyc(1);
    reset = 1'b1;
    expect_out("mid_reset", 0, 0, 0);
    cyc(9);
    expect_out("post_reset_wait", 0, 0, 0);
    cyc(1);
    expect_out("post_reset_tick", 1, 1, 0);

    // DIV=1 instance: a step every run cycle.
    run1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check($sformatf("div1.counter%0d", k), int'(counter1), k % 6);
      check($sformatf("div1.tick%0d", k), int'(tick1), 1);
      check($sformatf("div1.wrap%0d", k), int'(wrap1), (k % 6 == 0) ? 1 : 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tick_generator_param.md
Name: tick_generator_param

Overview:
- Parametrised successor to the fixed 1 kHz divider plus counter tick pair.
- A single-clock-domain prescaler produces a one-cycle tick enable; no derived clocks.
- The enable drives a wrap-around up/down counter with run/stop, clear and preload.
- Sits beside the processor subsystem as the timebase for stopwatch/display logic; o_counter feeds the GPIO/display path directly.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 1_000, tick rate in Hz. DIV = CLK_HZ/TICK_HZ (integer); DIV >= 1 required, elaboration error otherwise.
- CNT_WIDTH, 14, counter width in bits.
- CNT_MAX, 9999, terminal count; must be <= 2^CNT_WIDTH - 1.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous reset, active-low (0 = reset).
- i_run  in  1  1 = prescaler and counter advance; 0 = both hold.
- i_clear  in  1  synchronous clear of counter and prescaler.
- i_load  in  1  one-cycle strobe; preload the counter from i_load_value.
- i_load_value  in  CNT_WIDTH  preload value.
- i_down  in  1  count direction: 0 = up, 1 = down.
- o_counter  out  CNT_WIDTH  current count, registered.
- o_tick  out  1  one-cycle pulse per counter step.
- o_wrap  out  1  one-cycle pulse when the counter wraps.

Behaviour:
- Reset (i_reset=0 at an edge): prescaler=0, o_counter=0, o_tick=0, o_wrap=0. Reset applied mid-count aborts the count immediately; there is no partial-tick carry-over.
- Priority at each edge: reset > i_clear > i_load > tick step > hold.
- i_clear=1:
  - Prescaler=0, o_counter=0, o_tick=0, o_wrap=0.
  - Takes effect regardless of i_run.
- i_load=1 (and no clear):
  - o_counter = i_load_value if i_load_value <= CNT_MAX, else CNT_MAX (clamp).
  - Prescaler=0; o_tick=0; o_wrap=0.
  - A tick coinciding with the load is discarded.
- Prescaler, when i_run=1:
  - Counts 0..DIV-1.
  - At the edge where prescaler==DIV-1: prescaler->0 and a tick step occurs.
  - Otherwise the prescaler increments and o_tick=0, o_wrap=0.
  - DIV=1: a tick step occurs on every run cycle.
- i_run=0: prescaler and o_counter hold; o_tick=0, o_wrap=0. On resuming, the prescaler continues from its held value, so the first tick arrives after the remaining cycles, not a full DIV.
- Tick step, up (i_down=0):
  - o_counter==CNT_MAX -> 0 with o_wrap=1.
  - Else o_counter+1 with o_wrap=0.
  - o_tick=1 on every tick step.
- Tick step, down (i_down=1):
  - o_counter==0 -> CNT_MAX with o_wrap=1.
  - Else o_counter-1.
  - o_tick=1 on every tick step.
- i_down is sampled only at a tick step. Changing i_down between ticks has no other effect.
- Latency and timing:
  - o_tick and o_wrap are registered and high in the same cycle the new o_counter value first appears.
  - Both are exactly one clock wide.
  - Tick period is exactly DIV clocks while i_run stays 1.
- Out-of-range state: if o_counter > CNT_MAX (unreachable by design), the next up step goes to 0 with wrap, and the next down step decrements.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), CNT_WIDTH=4, CNT_MAX=5.
- Reset then run: i_reset=0 for 3 cycles, then release with i_run=1, i_down=0 -> o_counter=0 until cycle 10 after release. o_tick pulses every 10 clocks, counter steps 1,2,3,4,5,0. o_wrap=1 only together with the 5->0 step.
- Down mode: load 2 with i_down=1 -> counter 2,1,0,5,4, with o_wrap on the 0->5 step. Each step is 10 clocks apart after the load.
- Pause: drop i_run for 7 cycles when prescaler=4 -> no tick during the pause. The next tick arrives 6 clocks after i_run returns.
- Clamp and priority:
  - i_load_value=12 -> o_counter=5.
  - i_clear and i_load together (load value 3) -> o_counter=0.
  - Load coinciding with a prescaler terminal -> o_counter equals the load value, o_tick=0.
- Reset mid-operation: i_reset=0 at counter=3, prescaler=7 -> the next cycle has all outputs 0. After release, the first tick comes a full 10 clocks later.
- DIV=1 variant (TICK_HZ=10): with i_run=1, o_tick stays high continuously. The counter steps 0..5 each clock and o_wrap is high every 6th cycle.
